// File: rtl/pipeline_skid_barrier.sv
// pipeline_skid_barrier: valid/ready pipeline stage with optional skid entry, flush and saturating stall counter.
// SKID=1 gives a registered inReady (two entries); SKID=0 gives a single entry with inReady passed through from outReady.
module pipeline_skid_barrier #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stallCount
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state;
    logic [WIDTH-1:0] main_q, skid_q;
    logic in_xfer, out_xfer;
    assign inReady   = (SKID != 0) ? (state != TWO) : ((state == EMPTY) || outReady);
    assign outValid  = state != EMPTY;
    assign occupancy = state;
    assign outData   = main_q;
    assign in_xfer   = inValid && inReady;
    assign out_xfer  = outValid && outReady;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            stallCount <= '0;
        end else begin
            if (outValid && !outReady && stallCount != '1)
                stallCount <= stallCount + 1'b1;
            // flush wins over every transition and leaves the data registers alone
            if (flush)
                state <= EMPTY;
            else
                case (state)
                    EMPTY: if (in_xfer) begin
                        state  <= ONE;
                        main_q <= inData;
                    end
                    ONE: if (in_xfer && out_xfer)
                        main_q <= inData;
                    else if (in_xfer) begin
                        state  <= TWO;
                        skid_q <= inData;
                    end else if (out_xfer)
                        state <= EMPTY;
                    TWO: if (out_xfer) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                    default: state <= EMPTY;
                endcase
        end
    end
endmodule

// File: tb/tb_pipeline_skid_barrier.sv
// tb_pipeline_skid_barrier: directed checks on SKID=1 and SKID=0 stages, then a randomized scoreboard run on both.
module tb_pipeline_skid_barrier;
    logic clk = 1'b0, rn;
    logic v1, ir1, ov1, or1, fl1, v0, ir0, ov0, or0, fl0;
    logic [7:0] d1, od1, d0, od0;
    logic [1:0] oc1, oc0;
    logic [3:0] sc1, sc0;
    int errors = 0, checks = 0;
    logic [7:0] q1[$], q0[$];
    logic hs_in1, hs_out1, hs_in0, hs_out0;

    always #5 clk = ~clk;

    pipeline_skid_barrier #(.WIDTH(8), .SKID(1), .CNT_W(4)) u1 (
        .clk(clk), .resetN(rn), .inValid(v1), .inReady(ir1), .inData(d1),
        .outValid(ov1), .outReady(or1), .outData(od1), .flush(fl1),
        .occupancy(oc1), .stallCount(sc1));

    pipeline_skid_barrier #(.WIDTH(8), .SKID(0), .CNT_W(4)) u0 (
        .clk(clk), .resetN(rn), .inValid(v0), .inReady(ir0), .inData(d0),
        .outValid(ov0), .outReady(or0), .outData(od0), .flush(fl0),
        .occupancy(oc0), .stallCount(sc0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rn = 1'b0;
        {v1, or1, fl1, v0, or0, fl0} = '0;
        d1 = '0;
        d0 = '0;
        #2;
        chk("rst_ir", ir1, 1);
        chk("rst_ov", ov1, 0);
        chk("rst_oc", oc1, 0);
        chk("rst_od", od1, 0);
        chk("rst_sc", sc1, 0);
        chk("rst_ir0", ir0, 1);
        #1 rn = 1'b1;
        // streaming at full rate
        or1 = 1; v1 = 1; d1 = 8'h11;
        step(); chk("s_od11", od1, 8'h11); chk("s_oc", oc1, 1); chk("s_ir", ir1, 1);
        d1 = 8'h22;
        step(); chk("s_od22", od1, 8'h22); chk("s_oc", oc1, 1); chk("s_ir", ir1, 1);
        d1 = 8'h33;
        step(); chk("s_od33", od1, 8'h33); chk("s_oc", oc1, 1); chk("s_ir", ir1, 1);
        v1 = 0;
        step(); chk("s_drain_oc", oc1, 0); chk("s_drain_ov", ov1, 0);
        // back-pressure into the skid entry
        or1 = 0; v1 = 1; d1 = 8'h0A;
        step(); chk("bp_oc1", oc1, 1); chk("bp_odA", od1, 8'h0A);
        d1 = 8'h0B;
        step(); chk("bp_oc2", oc1, 2); chk("bp_ir0", ir1, 0);
        d1 = 8'h0C;
        step(); chk("bp_hold_oc", oc1, 2); chk("bp_hold_od", od1, 8'h0A); chk("bp_sc", sc1, 2);
        or1 = 1;
        step(); chk("bp_odB", od1, 8'h0B); chk("bp_oc_after", oc1, 1); chk("bp_ir1", ir1, 1);
        step(); chk("bp_odC", od1, 8'h0C); chk("bp_oc_c", oc1, 1);
        v1 = 0;
        step(); chk("bp_empty", oc1, 0);
        // flush while full with a concurrent push
        or1 = 0; v1 = 1; d1 = 8'h05;
        step(); d1 = 8'h06;
        step(); chk("fl_pre_oc", oc1, 2);
        fl1 = 1; d1 = 8'h07;
        #1 chk("fl_ir", ir1, 0); chk("fl_ov", ov1, 1);
        step(); chk("fl_oc", oc1, 0); chk("fl_ov0", ov1, 0); chk("fl_od_kept", od1, 8'h05); chk("fl_sc", sc1, 4);
        fl1 = 0; v1 = 0; or1 = 1;
        step(); chk("fl_no7_ov", ov1, 0);
        step(); chk("fl_no7_oc", oc1, 0);
        // asynchronous reset between edges while in TWO
        or1 = 0; v1 = 1; d1 = 8'h01;
        step(); d1 = 8'h02;
        step(); chk("ar_pre", oc1, 2);
        #2 rn = 1'b0;
        #1;
        chk("ar_oc", oc1, 0); chk("ar_ov", ov1, 0); chk("ar_od", od1, 0);
        chk("ar_sc", sc1, 0); chk("ar_ir", ir1, 1);
        #1 rn = 1'b1;
        or1 = 1; d1 = 8'h09;
        step(); chk("first_edge_od", od1, 8'h09); chk("first_edge_oc", oc1, 1);
        // stall counter saturation
        or1 = 0; v1 = 0;
        for (int i = 0; i < 20; i++) step();
        chk("sat15", sc1, 15);
        step(); chk("sat_hold", sc1, 15);
        or1 = 1;
        step(); chk("sat_drain", oc1, 0); chk("sat_keep", sc1, 15);
        // SKID=0 pass-through ready
        or0 = 1; v0 = 1; d0 = 8'h40;
        #1 chk("n_ir_empty", ir0, 1);
        step(); chk("n_od40", od0, 8'h40); chk("n_ir_full", ir0, 1);
        d0 = 8'h41;
        step(); chk("n_od41", od0, 8'h41); chk("n_oc", oc0, 1);
        or0 = 0;
        #1 chk("n_ir_blocked", ir0, 0);
        or0 = 1; v0 = 0;
        step(); chk("n_empty", oc0, 0);
        // randomized scoreboard on both stages
        for (int i = 0; i < 10000; i++) begin
            v1 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1));
            fl1 = ($urandom_range(0, 31) == 0); d1 = 8'($urandom);
            v0 = 1'($urandom_range(0, 1)); or0 = 1'($urandom_range(0, 1));
            fl0 = ($urandom_range(0, 31) == 0); d0 = 8'($urandom);
            #3;
            chk("r1_oc", oc1, q1.size());
            chk("r1_ir", ir1, q1.size() < 2);
            chk("r0_oc", oc0, q0.size());
            chk("r0_ir", ir0, q0.size() == 0 || or0);
            if (ov1 && q1.size() > 0) chk("r1_data", od1, q1[0]);
            if (ov0 && q0.size() > 0) chk("r0_data", od0, q0[0]);
            hs_in1 = v1 && ir1; hs_out1 = ov1 && or1;
            hs_in0 = v0 && ir0; hs_out0 = ov0 && or0;
            step();
            if (hs_out1 && q1.size() > 0) void'(q1.pop_front());
            if (hs_in1) q1.push_back(d1);
            if (fl1) q1.delete();
            if (hs_out0 && q0.size() > 0) void'(q0.pop_front());
            if (hs_in0) q0.push_back(d0);
            if (fl0) q0.delete();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
